pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//  Inverse of the pulse-shortening stage. Takes single-cycle strike pulses from
//  the drum-pad path and holds each one as a level for a fixed number of cycles.
//  Each channel then enforces a dead time before it accepts the next strike.
//  Sits between the pad/score logic and the LED/sound drivers, which need held levels.
// PARAMETERS
//  NUM_CH       4     number of independent pad channels
//  HOLD_CYCLES  1000  cycles the output stays high per accepted pulse (>=1)
//  GAP_CYCLES   200   cycles of forced-low dead time after a hold (>=0; 0 = none)
// PORTS
//  Clock        in   1       system clock, all logic on posedge
//  Reset_n      in   1       asynchronous, active-low reset
//  Pulso        in   NUM_CH  one-cycle strike pulses, one bit per channel
//  Sostenida    out  NUM_CH  stretched level per channel
//  Perdido      out  NUM_CH  1-cycle flag: pulse arrived but was rejected
//  Activo       out  1       OR of all Sostenida bits (registered)
// BEHAVIOUR
//  - Reset (Reset_n=0, async): all channels go to IDLE and all counters clear.
//    Sostenida=0, Perdido=0, Activo=0 immediately. These hold until the first edge after release.
//  - Channels are fully independent. Simultaneous pulses on several channels are all served.
//  - Per-channel FSM states: IDLE, HOLD, GAP.
//    IDLE: Pulso=1 at edge t -> HOLD, cnt=HOLD_CYCLES-1. Sostenida=1 from edge t (registered),
//          so it is visible in the cycle after the pulse. Latency is 1 cycle.
//    HOLD: Sostenida=1 for exactly HOLD_CYCLES cycles. cnt decrements each edge.
//          When cnt==0: go to GAP with cnt=GAP_CYCLES-1, or to IDLE if GAP_CYCLES==0.
//    GAP:  Sostenida=0. cnt decrements. When cnt==0 -> IDLE.
//  - Pulse during GAP: ignored. Perdido=1 for one cycle. State is unchanged.
//  - Pulse during HOLD: see CONFIGURATION.
//  - GAP_CYCLES==0 and a pulse on the same edge that HOLD expires: the pulse is accepted.
//    The FSM reloads HOLD and Sostenida stays high with no low cycle.
//  - Pulse held high for several cycles (malformed input): only the first cycle is a
//    new pulse. Later cycles are treated as ordinary pulses under the state rules above.
//  - Counter width = $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). Down-count only, never wraps.
//  - Reset asserted mid-HOLD or mid-GAP: the channel aborts to IDLE with no residual output.
//  - Activo = |Sostenida, registered. It lags Sostenida by 0 cycles because it is computed from next-state.
// CONFIGURATION
//  Macro PULSE_STRETCHER_RETRIGGER_EN.
//  Defined: a pulse in HOLD reloads cnt=HOLD_CYCLES-1. Output continues with no glitch.
//           Perdido stays 0.
//  Undefined: a pulse in HOLD is ignored and Perdido=1 for one cycle. The hold length is unchanged.
// STRUCTURE
//  Package pulse_stretcher_pkg:
//    - enum st_e {IDLE, HOLD, GAP}
//    - function cnt_width(hold, gap)
//  Sub-module stretch_channel: one FSM plus counter, instantiated NUM_CH times by a generate loop.
//  The top level only adds the Activo OR-reduce register.
// TESTING
//  1. HOLD=4, GAP=2, pulse ch0 at cycle 10 -> Sostenida[0] high cycles 11-14, low from 15.
//     Perdido=0 throughout.
//  2. Same setup, second pulse ch0 at cycle 15 (in GAP) -> Perdido[0]=1 at cycle 16, no new hold.
//     Pulse at 17 (IDLE) -> hold on cycles 18-21.
//  3. HOLD=4, pulse at 10 and again at 12:
//     with RETRIGGER_EN -> high cycles 11-16, Perdido=0;
//     without it -> high 11-14 and Perdido[0]=1 at cycle 13.
//  4. GAP=0, HOLD=3, pulses at 10 and 13 -> Sostenida high continuously cycles 11-16.
//  5. Pulses on ch0..ch3 on the same cycle -> all four outputs high the next cycle, Activo=1.
//     Activo drops when the last channel ends.
//  6. Reset_n low mid-HOLD (cycle 12 of case 1) -> Sostenida=0 and Activo=0 immediately
//     (asynchronous). After release, a new pulse gives a full-length hold.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: channel FSM states and counter sizing helper
package pulse_stretcher_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} st_e;
  function automatic int cnt_width(input int hold, input int gap);
    return $clog2((hold > gap ? hold : gap) + 1);
  endfunction
endpackage

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: strike pulses in, held levels and reject flags out
interface pulse_stretcher_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0] Pulso;
  logic [NUM_CH-1:0] Sostenida;
  logic [NUM_CH-1:0] Perdido;
  logic Activo;
  modport master(output Pulso, input Sostenida, Perdido, Activo);
  modport slave(input Pulso, output Sostenida, Perdido, Activo);
endinterface

// File: rtl/pulse_stretcher_stretch_channel.sv
// stretch_channel: one IDLE/HOLD/GAP FSM with down-counter; PULSE_STRETCHER_RETRIGGER_EN lets a pulse in HOLD restart the hold
module stretch_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 200
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic pulso,
  output logic sostenida,
  output logic perdido,
  output logic sost_nxt
);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  st_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic lost, reload;
  // next state: a pulse reloads HOLD when retriggering, or when the hold expires with no dead time
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    lost = 1'b0;
    reload = pulso && (RETRIG || (cnt == '0 && GAP_CYCLES == 0));
    case (st)
      IDLE: if (pulso) begin
        st_n = HOLD;
        cnt_n = HOLD_LD;
      end
      HOLD: begin
        lost = pulso && !reload;
        if (reload) cnt_n = HOLD_LD;
        else if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (GAP_CYCLES != 0) begin
          st_n = GAP;
          cnt_n = GAP_LD;
        end
        else st_n = IDLE;
      end
      GAP: begin
        lost = pulso;
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
    sost_nxt = (st_n == HOLD);
  end
  // state, counter and registered outputs; reset aborts any hold or gap at once
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      st <= IDLE;
      cnt <= '0;
      sostenida <= 1'b0;
      perdido <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      sostenida <= sost_nxt;
      perdido <= lost;
    end
  end
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: per-channel strike stretcher with dead time; retrigger via PULSE_STRETCHER_RETRIGGER_EN
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 200
) (
  input logic Clock,
  input logic Reset_n,
  pulse_stretcher_if.slave bus
);
  logic [NUM_CH-1:0] sost_nxt;
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      stretch_channel #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
      ) u_ch (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .pulso    (bus.Pulso[i]),
        .sostenida(bus.Sostenida[i]),
        .perdido  (bus.Perdido[i]),
        .sost_nxt (sost_nxt[i])
      );
    end
  endgenerate
  // Activo registered from next-state so it tracks Sostenida on the same cycle
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) bus.Activo <= 1'b0;
    else bus.Activo <= |sost_nxt;
  end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: scoreboard bench with two DUTs (HOLD=4/GAP=2 and HOLD=3/GAP=0)
module tb_pulse_stretcher;
  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;
  pulse_stretcher_if #(.NUM_CH(4)) bus_a ();
  pulse_stretcher_if #(.NUM_CH(4)) bus_b ();
  pulse_stretcher #(.NUM_CH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut_a (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus_a.slave)
  );
  pulse_stretcher #(.NUM_CH(4), .HOLD_CYCLES(3), .GAP_CYCLES(0)) dut_b (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus_b.slave)
  );
`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  int st[2][4];
  int rem[2][4];
  int hh[2] = '{4, 3};
  int gg[2] = '{2, 0};
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got={sost,perd,act}=%b required=%b", tag, cyc, got, exp);
    end
  endtask
  // reference: st 0=idle 1=hold 2=gap, rem = cycles left in the current state
  task automatic mdl(input int d, input logic [3:0] p, output logic [8:0] e);
    logic [3:0] s, l;
    s = '0;
    l = '0;
    for (int c = 0; c < 4; c++) begin
      case (st[d][c])
        0: if (p[c]) begin
          st[d][c] = 1;
          rem[d][c] = hh[d];
        end
        1: if (p[c] && RT) rem[d][c] = hh[d];
        else begin
          rem[d][c]--;
          if (rem[d][c] == 0 && gg[d] == 0 && p[c]) rem[d][c] = hh[d];
          else begin
            l[c] = p[c];
            if (rem[d][c] == 0) begin
              st[d][c] = gg[d] > 0 ? 2 : 0;
              rem[d][c] = gg[d];
            end
          end
        end
        default: begin
          l[c] = p[c];
          rem[d][c]--;
          if (rem[d][c] == 0) st[d][c] = 0;
        end
      endcase
      s[c] = (st[d][c] == 1);
    end
    e = {s, l, |s};
  endtask
  task automatic step(input logic [3:0] pa, input logic [3:0] pb);
    logic [8:0] e;
    @(negedge Clock);
    bus_a.Pulso = pa;
    bus_b.Pulso = pb;
    mdl(0, pa, e);
    q_a.push_back(e);
    mdl(1, pb, e);
    q_b.push_back(e);
    @(posedge Clock);
    #1;
    cyc++;
    check("dut_a", {bus_a.Sostenida, bus_a.Perdido, bus_a.Activo}, q_a.pop_front());
    check("dut_b", {bus_b.Sostenida, bus_b.Perdido, bus_b.Activo}, q_b.pop_front());
  endtask
  logic [7:0] tbl[] = '{8'h11, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h10,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00,
                        8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  initial begin
    logic [3:0] ra, rb;
    bus_a.Pulso = '0;
    bus_b.Pulso = '0;
    #1;
    check("reset_a", {bus_a.Sostenida, bus_a.Perdido, bus_a.Activo}, 9'h0);
    check("reset_b", {bus_b.Sostenida, bus_b.Perdido, bus_b.Activo}, 9'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (3) step(4'h0, 4'h0);
    foreach (tbl[k]) step(tbl[k][7:4], tbl[k][3:0]);
    repeat (300) begin
      for (int c = 0; c < 4; c++) begin
        ra[c] = ($urandom_range(0, 3) == 0);
        rb[c] = ($urandom_range(0, 3) == 0);
      end
      step(ra, rb);
    end
    repeat (10) step(4'h0, 4'h0);
    step(4'h1, 4'h1);
    step(4'h0, 4'h0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_a", {bus_a.Sostenida, bus_a.Perdido, bus_a.Activo}, 9'h0);
    check("async_rst_b", {bus_b.Sostenida, bus_b.Perdido, bus_b.Activo}, 9'h0);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        st[d][c] = 0;
        rem[d][c] = 0;
      end
    @(negedge Clock);
    Reset_n = 1'b1;
    step(4'h1, 4'h2);
    repeat (8) step(4'h0, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
